// File: rtl/hex_rr_arbiter_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter:
// sizes, FSM state encoding and the rotate-and-pick search.
package hex_arb_pkg;

    localparam int unsigned NREQ  = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // First set bit of v searching ptr, ptr+1, ..., 15, 0, ..., ptr-1.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] v,
                                                 input logic [IDX_W-1:0] ptr);
        logic [NREQ-1:0]  rot;
        logic [IDX_W-1:0] res;
        rot = (v >> ptr) | (v << (5'd16 - {1'b0, ptr}));
        res = '0;
        // Descending scan so the lowest rotated position wins.
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (rot[i-1]) res = ptr + IDX_W'(i - 1);
        end
        return res;
    endfunction

endpackage

// File: rtl/hex_rr_arbiter_if.sv
// Request/grant bundle between the 16 clients and the arbiter.
interface hex_rr_arbiter_if;
    import hex_arb_pkg::*;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid
    );

endinterface

// File: rtl/hex_rr_arbiter_onehot16_encoder.sv
// 16-to-4 one-hot to binary encoder, purely combinational.
module onehot16_encoder
    import hex_arb_pkg::*;
(
    input  logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (onehot[i]) idx = idx | IDX_W'(i);
        end
    end

endmodule

// File: rtl/hex_rr_arbiter.sv
// Round-robin arbiter for 16 clients with grant locking and a bounded
// hold time; registers a one-hot grant and its binary index.
module hex_rr_arbiter
    import hex_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    hex_rr_arbiter_if.slave     bus
);

    localparam int unsigned     HCW      = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HCW-1:0]  HOLD_SAT = (HOLD_MAX == 0) ? HCW'(1) : HCW'(HOLD_MAX);

    state_t           state, next_state;
    logic [IDX_W-1:0] ptr, next_ptr;
    logic [HCW-1:0]   hold_cnt, next_cnt;
    logic [NREQ-1:0]  next_grant;
    logic [IDX_W-1:0] next_idx;
    logic [NREQ-1:0]  others;
    logic [IDX_W-1:0] winner;
    logic             keep;

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        next_cnt   = hold_cnt;
        next_grant = bus.grant;
        others     = bus.req & ~bus.grant;
        winner     = '0;
        keep       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req != '0) begin
                    winner     = rr_pick(bus.req, ptr);
                    next_grant = NREQ'(1) << winner;
                    next_cnt   = HCW'(1);
                    next_ptr   = winner + IDX_W'(1);
                    next_state = GRANT;
                end
            end
            GRANT: begin
                // With nobody else waiting the holder keeps the grant past the limit.
                keep = bus.req[bus.grant_idx] &&
                       ((HOLD_MAX == 0) || (hold_cnt < HOLD_SAT) || (others == '0));
                if (keep) begin
                    if (hold_cnt != HOLD_SAT) next_cnt = hold_cnt + HCW'(1);
                end else if (others != '0) begin
                    winner     = rr_pick(others, ptr);
                    next_grant = NREQ'(1) << winner;
                    next_cnt   = HCW'(1);
                    next_ptr   = winner + IDX_W'(1);
                end else begin
                    next_grant = '0;
                    next_state = IDLE;
                end
            end
            default: begin
                next_grant = '0;
                next_state = IDLE;
            end
        endcase
    end

    onehot16_encoder u_enc (
        .onehot (next_grant),
        .idx    (next_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            hold_cnt        <= '0;
            bus.grant       <= '0;
            bus.grant_idx   <= '0;
            bus.grant_valid <= 1'b0;
        end else begin
            state           <= next_state;
            ptr             <= next_ptr;
            hold_cnt        <= next_cnt;
            bus.grant       <= next_grant;
            bus.grant_idx   <= next_idx;
            bus.grant_valid <= (next_grant != '0);
        end
    end

endmodule
